// File: rtl/vid_arb_pkg.sv
// vid_arb_pkg: shared types for the video memory arbiter.
//   - requester id enum (text / action / background layer fetchers)
//   - NumReq, FSM state typedef, tag struct {id, len} stored per outstanding command
//   - small helpers for round-robin stepping and one-hot decode
package vid_arb_pkg;

  localparam int NumReq = 3;

  typedef enum logic [1:0] {
    ReqText   = 2'd0,
    ReqAction = 2'd1,
    ReqBack   = 2'd2
  } req_id_e;

  typedef enum logic {
    StIdle = 1'b0,
    StCmd  = 1'b1
  } arb_state_e;

  typedef struct packed {
    req_id_e    id;
    logic [7:0] len;
  } tag_t;

  localparam int TagWidth = $bits(tag_t);

  // (base + k) mod 3, for k in 0..2
  function automatic req_id_e rr_step(input req_id_e base, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return req_id_e'(s[1:0]);
  endfunction

  function automatic logic [NumReq-1:0] id_onehot(input req_id_e id);
    logic [NumReq-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/vid_arb_tag_fifo.sv
// vid_arb_tag_fifo: synchronous FIFO holding one tag per outstanding memory
// command. Head entry is visible on pop_data whenever empty is low.
// Ports:
//   clk, srst            clock and synchronous active-high reset
//   push, push_data      write an entry (ignored when full)
//   pop                  drop the head entry (ignored when empty)
//   pop_data             current head entry
//   full, empty          occupancy flags
// Depth must be a power of two (>= 2) so the pointers wrap naturally.
module vid_arb_tag_fifo #(
  parameter int Width = 10,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_reg [Depth];
  logic [AddrW-1:0] wr_ptr_reg;
  logic [AddrW-1:0] rd_ptr_reg;
  logic [AddrW:0]   count_reg;

  logic push_ok;
  logic pop_ok;

  assign full     = (count_reg == (AddrW + 1)'(Depth));
  assign empty    = (count_reg == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_reg[rd_ptr_reg];

  // Storage has no reset; entries are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/vid_mem_arbiter.sv
// vid_mem_arbiter: round-robin arbiter between three layer fetchers (text,
// action, background) sharing one burst-read memory port. Each accepted
// command pushes {id, len} into a tag FIFO; in-order read beats are routed
// back to the owner of the head tag with one cycle of latency.
// Ports:
//   vid_clk, vid_reset                 clock, synchronous active-high reset
//   frame_start_strobe                 restarts round-robin at requester 0
//   req_valid/req_addr/req_len         per-requester burst requests (len = beats-1)
//   req_ready                          one-cycle acceptance pulse per requester
//   mem_cmd_valid/addr/len, mem_cmd_ready   memory command handshake
//   mem_rd_valid, mem_rd_data          read-data beats from memory
//   rd_valid, rd_data, rd_last         routed beats (registered)
//   err_unexpected_rd                  sticky: beat arrived with nothing outstanding
// Optional feature macro VID_ARB_STATS_EN adds grant_count (3 x 16-bit,
// saturating per-requester accepted-command counters, cleared each frame).
module vid_mem_arbiter
  import vid_arb_pkg::*;
#(
  parameter int AddrWidth = 24,
  parameter int DataWidth = 32,
  parameter int TagDepth  = 4
) (
  input  logic                          vid_clk,
  input  logic                          vid_reset,
  input  logic                          frame_start_strobe,
  input  logic [NumReq-1:0]             req_valid,
  input  logic [NumReq*AddrWidth-1:0]   req_addr,
  input  logic [NumReq*8-1:0]           req_len,
  output logic [NumReq-1:0]             req_ready,
  output logic                          mem_cmd_valid,
  output logic [AddrWidth-1:0]          mem_cmd_addr,
  output logic [7:0]                    mem_cmd_len,
  input  logic                          mem_cmd_ready,
  input  logic                          mem_rd_valid,
  input  logic [DataWidth-1:0]          mem_rd_data,
  output logic [NumReq-1:0]             rd_valid,
  output logic [DataWidth-1:0]          rd_data,
  output logic                          rd_last,
  output logic                          err_unexpected_rd
`ifdef VID_ARB_STATS_EN
  ,
  output logic [NumReq*16-1:0]          grant_count
`endif
);

  // Unpacked views of the flattened request buses
  logic [AddrWidth-1:0] req_addr_arr [NumReq];
  logic [7:0]           req_len_arr  [NumReq];

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
    assign req_addr_arr[gi] = req_addr[gi*AddrWidth +: AddrWidth];
    assign req_len_arr[gi]  = req_len[gi*8 +: 8];
  end

  // ---------------- command side ----------------
  arb_state_e           state_reg;
  req_id_e              rr_ptr_reg;     // highest-priority requester
  req_id_e              win_id_reg;
  logic [AddrWidth-1:0] cmd_addr_reg;
  logic [7:0]           cmd_len_reg;

  logic              grant_any;
  req_id_e           winner;
  req_id_e           cand;
  logic              cmd_accept;
  logic [NumReq-1:0] win_onehot;

  logic                fifo_full;
  logic                fifo_empty;
  logic [TagWidth-1:0] fifo_head_raw;
  tag_t                head;
  tag_t                push_tag;
  logic                pop;

  // Scan from lowest to highest priority so the highest-priority valid
  // requester is the last to write winner.
  always_comb begin
    grant_any = 1'b0;
    winner    = ReqText;
    cand      = ReqText;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand = rr_step(rr_ptr_reg, 2'(k));
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        winner    = cand;
      end
    end
  end

  assign mem_cmd_valid = (state_reg == StCmd);
  assign mem_cmd_addr  = cmd_addr_reg;
  assign mem_cmd_len   = cmd_len_reg;
  assign cmd_accept    = mem_cmd_valid && mem_cmd_ready;
  assign win_onehot    = id_onehot(win_id_reg);
  assign req_ready     = cmd_accept ? win_onehot : '0;

  always_ff @(posedge vid_clk) begin
    if (vid_reset) begin
      state_reg    <= StIdle;
      rr_ptr_reg   <= ReqText;
      win_id_reg   <= ReqText;
      cmd_addr_reg <= '0;
      cmd_len_reg  <= '0;
    end else begin
      case (state_reg)
        StIdle: begin
          // Grant only while a tag slot is free; the push happens on accept.
          if (grant_any && !fifo_full) begin
            state_reg    <= StCmd;
            win_id_reg   <= winner;
            cmd_addr_reg <= req_addr_arr[winner];
            cmd_len_reg  <= req_len_arr[winner];
            rr_ptr_reg   <= rr_step(winner, 2'd1);
          end
        end
        StCmd: begin
          if (mem_cmd_ready) state_reg <= StIdle;
        end
        default: state_reg <= StIdle;
      endcase
      // Frame start overrides any pointer update from a grant this cycle.
      if (frame_start_strobe) rr_ptr_reg <= ReqText;
    end
  end

  // ---------------- tag FIFO ----------------
  assign push_tag = '{id: win_id_reg, len: cmd_len_reg};
  assign head     = tag_t'(fifo_head_raw);

  vid_arb_tag_fifo #(
    .Width (TagWidth),
    .Depth (TagDepth)
  ) u_tag_fifo (
    .clk       (vid_clk),
    .srst      (vid_reset),
    .push      (cmd_accept),
    .push_data (push_tag),
    .pop       (pop),
    .pop_data  (fifo_head_raw),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------- read-data routing ----------------
  logic [NumReq-1:0]    rd_valid_reg;
  logic [DataWidth-1:0] rd_data_reg;
  logic                 rd_last_reg;
  logic [7:0]           beat_cnt_reg;
  logic                 err_reg;
  logic                 beat_ok;

  assign beat_ok = mem_rd_valid && !fifo_empty;
  assign pop     = beat_ok && (beat_cnt_reg == head.len);

  always_ff @(posedge vid_clk) begin
    if (vid_reset) begin
      rd_valid_reg <= '0;
      rd_data_reg  <= '0;
      rd_last_reg  <= 1'b0;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      rd_valid_reg <= beat_ok ? id_onehot(head.id) : '0;
      rd_last_reg  <= pop;
      if (beat_ok) rd_data_reg <= mem_rd_data;
      if (pop)          beat_cnt_reg <= '0;
      else if (beat_ok) beat_cnt_reg <= beat_cnt_reg + 8'd1;
      // A beat with nothing outstanding is dropped and flagged.
      if (mem_rd_valid && fifo_empty) err_reg <= 1'b1;
    end
  end

  assign rd_valid          = rd_valid_reg;
  assign rd_data           = rd_data_reg;
  assign rd_last           = rd_last_reg;
  assign err_unexpected_rd = err_reg;

`ifdef VID_ARB_STATS_EN
  // ---------------- per-requester grant statistics ----------------
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_stats
    logic [15:0] count_reg;
    logic        hit;

    assign hit = cmd_accept && win_onehot[gi];

    always_ff @(posedge vid_clk) begin
      if (vid_reset) begin
        count_reg <= '0;
      end else if (frame_start_strobe) begin
        // A grant coinciding with frame start belongs to the new frame.
        count_reg <= hit ? 16'd1 : 16'd0;
      end else if (hit && (count_reg != 16'hFFFF)) begin
        count_reg <= count_reg + 16'd1;
      end
    end

    assign grant_count[gi*16 +: 16] = count_reg;
  end
`endif

endmodule

// File: tb/tb_vid_mem_arbiter.sv
// Directed self-checking bench for vid_mem_arbiter (default parameters).
module tb_vid_mem_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;

  logic           vid_clk = 1'b0;
  logic           vid_reset;
  logic           frame_start_strobe;
  logic [2:0]     req_valid;
  logic [3*AW-1:0] req_addr;
  logic [23:0]    req_len;
  logic [2:0]     req_ready;
  logic           mem_cmd_valid;
  logic [AW-1:0]  mem_cmd_addr;
  logic [7:0]     mem_cmd_len;
  logic           mem_cmd_ready;
  logic           mem_rd_valid;
  logic [DW-1:0]  mem_rd_data;
  logic [2:0]     rd_valid;
  logic [DW-1:0]  rd_data;
  logic           rd_last;
  logic           err_unexpected_rd;
`ifdef VID_ARB_STATS_EN
  logic [47:0]    grant_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 vid_clk = ~vid_clk;

  vid_mem_arbiter dut (
    .vid_clk            (vid_clk),
    .vid_reset          (vid_reset),
    .frame_start_strobe (frame_start_strobe),
    .req_valid          (req_valid),
    .req_addr           (req_addr),
    .req_len            (req_len),
    .req_ready          (req_ready),
    .mem_cmd_valid      (mem_cmd_valid),
    .mem_cmd_addr       (mem_cmd_addr),
    .mem_cmd_len        (mem_cmd_len),
    .mem_cmd_ready      (mem_cmd_ready),
    .mem_rd_valid       (mem_rd_valid),
    .mem_rd_data        (mem_rd_data),
    .rd_valid           (rd_valid),
    .rd_data            (rd_data),
    .rd_last            (rd_last),
    .err_unexpected_rd  (err_unexpected_rd)
`ifdef VID_ARB_STATS_EN
    ,
    .grant_count        (grant_count)
`endif
  );

  task automatic tick;
    @(posedge vid_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  logic [AW-1:0] addr_tab [3];
  int            cnt;
  int            exp_id;
  int            prev_id;

  initial begin
    addr_tab[0] = 24'h000A00;
    addr_tab[1] = 24'h000B00;
    addr_tab[2] = 24'h000C00;

    vid_reset = 1'b1; frame_start_strobe = 1'b0; req_valid = '0; req_addr = '0;
    req_len = '0; mem_cmd_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    tick; tick; tick;
    vid_reset = 1'b0;

    // Reset state
    check("rst_cmd_valid", 64'(mem_cmd_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_last", 64'(rd_last), 64'd0);
    check("rst_err", 64'(err_unexpected_rd), 64'd0);
    check("rst_cmd_addr", 64'(mem_cmd_addr), 64'd0);
    $display("txn reset: outputs checked");

    // Single request: requester 1, addr 0x000100, len 3
    req_addr[1*AW +: AW] = 24'h000100;
    req_len[1*8 +: 8]    = 8'd3;
    req_valid            = 3'b010;
    #1;
    check("single_no_cmd_yet", 64'(mem_cmd_valid), 64'd0);
    tick;
    check("single_cmd_valid", 64'(mem_cmd_valid), 64'd1);
    check("single_cmd_addr", 64'(mem_cmd_addr), 64'h000100);
    check("single_cmd_len", 64'(mem_cmd_len), 64'd3);
    check("single_ready_wait", 64'(req_ready), 64'd0);
    tick;
    check("single_cmd_held", 64'(mem_cmd_addr), 64'h000100);
    mem_cmd_ready = 1'b1;
    #1;
    check("single_req_ready", 64'(req_ready), 64'b010);
    tick;
    req_valid = '0;
    check("single_cmd_done", 64'(mem_cmd_valid), 64'd0);
    for (int b = 0; b < 4; b++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = 32'hA000_0000 + 32'(b);
      tick;
      check("single_rd_valid", 64'(rd_valid), 64'b010);
      check("single_rd_data", 64'(rd_data), 64'hA000_0000 + 64'(b));
      check("single_rd_last", 64'(rd_last), (b == 3) ? 64'd1 : 64'd0);
    end
    mem_rd_valid = 1'b0;
    tick;
    check("single_rd_idle", 64'(rd_valid), 64'd0);
    $display("txn single: req1 burst of 4 beats");

    // Round-robin with all requesters valid, 1-beat bursts
    frame_start_strobe = 1'b1;
    tick;
    frame_start_strobe = 1'b0;
    for (int r = 0; r < 3; r++) begin
      req_addr[r*AW +: AW] = addr_tab[r];
      req_len[r*8 +: 8]    = 8'd0;
    end
    req_valid = 3'b111;
    prev_id   = 0;
    for (int g = 0; g < 6; g++) begin
      exp_id = g % 3;
      tick;
      check("rr_cmd_valid", 64'(mem_cmd_valid), 64'd1);
      check("rr_cmd_addr", 64'(mem_cmd_addr), 64'(addr_tab[exp_id]));
      check("rr_req_ready", 64'(req_ready), 64'(3'b001 << exp_id));
      if (g > 0) begin
        check("rr_rd_route", 64'(rd_valid), 64'(3'b001 << prev_id));
        check("rr_rd_last", 64'(rd_last), 64'd1);
      end
      mem_rd_valid = 1'b0;
      tick;
      check("rr_gap", 64'(mem_cmd_valid), 64'd0);
      mem_rd_valid = 1'b1;
      prev_id      = exp_id;
      $display("txn rr: grant %0d to req %0d", g, exp_id);
    end
    req_valid = '0;
    tick;
    mem_rd_valid = 1'b0;
    check("rr_final_route", 64'(rd_valid), 64'b100);
    check("rr_no_err", 64'(err_unexpected_rd), 64'd0);

    // Frame start after a grant to 0 sends the next grant back to 0
    req_valid = 3'b111;
    tick;
    check("fs_first_grant", 64'(mem_cmd_addr), 64'(addr_tab[0]));
    frame_start_strobe = 1'b1;
    tick;
    frame_start_strobe = 1'b0;
    mem_rd_valid       = 1'b1;
    tick;
    mem_rd_valid = 1'b0;
    check("fs_second_grant", 64'(mem_cmd_addr), 64'(addr_tab[0]));
    check("fs_second_ready", 64'(req_ready), 64'b001);
    tick;
    req_valid    = '0;
    mem_rd_valid = 1'b1;
    tick;
    mem_rd_valid = 1'b0;
    check("fs_drain_route", 64'(rd_valid), 64'b001);
    $display("txn frame_start: grant 0 repeated after strobe");

    // FIFO full: only TagDepth commands issue without returned data
    req_len[0*8 +: 8] = 8'd1;
    req_valid = 3'b001;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (mem_cmd_valid && mem_cmd_ready) cnt++;
    end
    check("full_cmd_count", 64'(cnt), 64'd4);
    check("full_stalled", 64'(mem_cmd_valid), 64'd0);
    mem_rd_valid = 1'b1;
    tick;
    check("full_beat0_last", 64'(rd_last), 64'd0);
    tick;
    check("full_beat1_last", 64'(rd_last), 64'd1);
    mem_rd_valid = 1'b0;
    tick;
    check("full_fifth_issued", 64'(mem_cmd_valid), 64'd1);
    check("full_fifth_ready", 64'(req_ready), 64'b001);
    tick;
    req_valid    = '0;
    mem_rd_valid = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (rd_last) cnt++;
    end
    mem_rd_valid = 1'b0;
    check("full_drain_lasts", 64'(cnt), 64'd4);
    tick;
    check("full_drain_idle", 64'(rd_valid), 64'd0);
    check("full_no_err", 64'(err_unexpected_rd), 64'd0);
    $display("txn fifo_full: 4 issued, 5th after first burst");

    // Unexpected read beat with nothing outstanding
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'hDEAD_BEEF;
    tick;
    mem_rd_valid = 1'b0;
    check("unexp_err_set", 64'(err_unexpected_rd), 64'd1);
    check("unexp_rd_valid", 64'(rd_valid), 64'd0);
    tick; tick;
    check("unexp_err_sticky", 64'(err_unexpected_rd), 64'd1);
    vid_reset = 1'b1;
    tick;
    vid_reset = 1'b0;
    check("unexp_err_cleared", 64'(err_unexpected_rd), 64'd0);
    check("unexp_rst_cmd", 64'(mem_cmd_valid), 64'd0);
    $display("txn unexpected_rd: sticky error until reset");

`ifdef VID_ARB_STATS_EN
    req_addr[2*AW +: AW] = addr_tab[2];
    req_len[2*8 +: 8]    = 8'd0;
    req_valid            = 3'b100;
    mem_cmd_ready        = 1'b1;
    tick;
    tick;
    req_valid = '0;
    check("stats_one", 64'(grant_count[32 +: 16]), 64'd1);
    mem_rd_valid = 1'b1;
    tick;
    mem_rd_valid = 1'b0;
    req_valid = 3'b100;
    tick;
    frame_start_strobe = 1'b1;
    tick;
    frame_start_strobe = 1'b0;
    req_valid = '0;
    check("stats_strobe_grant", 64'(grant_count[32 +: 16]), 64'd1);
    frame_start_strobe = 1'b1;
    mem_rd_valid       = 1'b1;
    tick;
    frame_start_strobe = 1'b0;
    mem_rd_valid       = 1'b0;
    check("stats_cleared", 64'(grant_count[32 +: 16]), 64'd0);
    $display("txn stats: grant_count[2] counted and cleared");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
